// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: controller state encoding and id-width helper.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_e;

  // Requester id width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping around.
module rr_arbiter
  import div_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  int w_idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    w_idx        = 0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = (int'(ptr) + off) % NREQ;
      if (!any && req[w_idx]) begin
        any                 = 1'b1;
        grant_onehot[w_idx] = 1'b1;
        grant_idx           = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NREQ requesters: accept, issue, wait for done, respond with id.
module div_arbiter
  import div_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 3,
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [WIDTH-1:0]      resp_quotient,
  output logic [WIDTH-1:0]      resp_remainder,
  output logic                  resp_div_zero,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  output div_state_e            dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and the payload is held while valid waits.

  div_state_e       r_state;
  div_state_e       w_next;
  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [NREQ-1:0]  w_grant_onehot;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_dvd;
  logic [WIDTH-1:0] w_sel_dvs;
  logic [ID_W-1:0]  w_ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req          (req_valid),
    .ptr          (r_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  always_comb begin
    w_sel_dvd = '0;
    w_sel_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_onehot[i]) begin
        w_sel_dvd = req_dividend[i*WIDTH +: WIDTH];
        w_sel_dvs = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && w_any;
  assign w_ptr_next = (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = (w_sel_dvs == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      // div_done is only trusted here; the divider has no reset and done can be stale.
      ST_WAIT:  if (div_done) w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_id       <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dz       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr      <= w_ptr_next;
        r_dividend <= w_sel_dvd;
        r_divisor  <= w_sel_dvs;
        r_id       <= w_grant_idx;
        r_dz       <= (w_sel_dvs == '0);
        if (w_sel_dvs == '0) begin
          r_quot <= '1;
          r_rem  <= w_sel_dvd;
        end
      end
      if (r_state == ST_WAIT && div_done) begin
        r_quot <= div_quotient;
        r_rem  <= div_remainder;
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready      = (r_state == ST_IDLE) ? (w_grant_onehot & {NREQ{rst_n}}) : '0;
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_id        = r_id;
  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;
  assign resp_div_zero  = r_dz;
  assign div_start      = (r_state == ST_ISSUE);
  assign div_dividend   = r_dividend;
  assign div_divisor    = r_divisor;
  assign dbg_state      = r_state;

endmodule
